// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM states and counter sizing for serial_adder_ctrl
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done handshakes; `sub` exists only with SERIAL_ADDER_SUB_EN
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic start_valid;
    logic start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic cin;
    logic done_valid;
    logic done_ready;
    logic [WIDTH-1:0] sum_out;
    logic cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
    modport master (output start_valid, a_in, b_in, cin, sub, done_ready,
                    input start_ready, done_valid, sum_out, cout);
    modport slave (input start_valid, a_in, b_in, cin, sub, done_ready,
                   output start_ready, done_valid, sum_out, cout);
`else
    modport master (output start_valid, a_in, b_in, cin, done_ready,
                    input start_ready, done_valid, sum_out, cout);
    modport slave (input start_valid, a_in, b_in, cin, done_ready,
                   output start_ready, done_valid, sum_out, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: single-bit full adder cell shared across all bit positions
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first; SERIAL_ADDER_SUB_EN adds A-B mode
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, b_load;
    logic [CW-1:0] cnt;
    logic carry, c_load, fa_sum, fa_cout;
`ifdef SERIAL_ADDER_SUB_EN
    // subtract as A + ~B + 1; cin is not used in that mode
    assign b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign c_load = bus.sub | bus.cin;
`else
    assign b_load = bus.b_in;
    assign c_load = bus.cin;
`endif
    full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .c(carry), .sum(fa_sum), .cout(fa_cout));
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.start_valid ? RUN : IDLE) :
                   (state == RUN)  ? ((cnt == CW'(WIDTH - 1)) ? DONE : RUN) :
                                     (bus.done_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start_valid) begin
                a_sr  <= bus.a_in;
                b_sr  <= b_load;
                carry <= c_load;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry  <= fa_cout;
                cnt    <= cnt + 1'b1;
            end
        end
    end
    assign bus.start_ready = (state == IDLE);
    assign bus.done_valid  = (state == DONE);
    assign bus.sum_out     = sum_sr;
    assign bus.cout        = carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic rand_dr = 1'b0;
    logic dr_fixed = 1'b1;
    logic rnd_bit = 1'b0;
    logic prev_dv = 1'b0;
    int last_hs = -1;
    logic [8:0] exp_q[$];
    int acc_q[$];

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();
    serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd_bit <= 1'($urandom);
    end
    assign bus.done_ready = rand_dr ? rnd_bit : dr_fixed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
        if (s) return {a >= b, a - b};
        return {1'b0, a} + {1'b0, b} + 9'(c);
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        bus.a_in = a;
        bus.b_in = b;
        bus.cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = s;
`endif
        bus.start_valid = 1'b1;
    endtask

    // called at a negedge with start_valid already high
    task automatic wait_accept(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        int n = 0;
        while (!bus.start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.start_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: start_ready stuck low after %0d cycles", n);
        end else begin
            exp_q.push_back(model(a, b, c, s));
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.start_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        @(negedge clk);
        drive(a, b, c, s);
        wait_accept(a, b, c, s);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.start_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 500), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_dv = 1'b0;
        end else begin
            if (bus.done_valid) begin
                chk("start_ready_in_done", 32'(bus.start_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: sum %0h cout %0b with nothing pending", bus.sum_out, bus.cout);
                end else begin
                    chk("result", {23'd0, bus.cout, bus.sum_out}, 32'(exp_q[0]));
                    if (!prev_dv && acc_q.size() != 0) chk("latency", 32'(cyc - acc_q.pop_front()), 32'd8);
                    if (bus.done_ready) begin
                        void'(exp_q.pop_front());
                        last_hs = cyc + 1;
                    end
                end
            end
            prev_dv = bus.done_valid;
        end
    end

    initial begin
        int hs;
        logic [7:0] ra, rb;
        logic rc, rs;
        bus.start_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.cin = 1'b0;
        bus1.start_valid = 1'b0;
        bus1.a_in = '0;
        bus1.b_in = '0;
        bus1.cin = 1'b0;
        bus1.done_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
        bus1.sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_start_ready", 32'(bus.start_ready), 32'd1);
        chk("reset_done_valid", 32'(bus.done_valid), 32'd0);
        chk("reset_sum", 32'(bus.sum_out), 32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;

        send(8'h5A, 8'h3C, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        send(8'h10, 8'h01, 1'b0, 1'b1);
        send(8'h01, 8'h02, 1'b1, 1'b1);
`endif
        drain();

        // backpressure with a second start pending throughout DONE
        dr_fixed = 1'b0;
        send(8'hC3, 8'h4D, 1'b1, 1'b0);
        drive(8'h12, 8'h34, 1'b0, 1'b0);
        for (int n = 0; n < 50 && !bus.done_valid; n++) @(negedge clk);
        chk("bp_done_seen", 32'(bus.done_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_no_accept", 32'(exp_q.size()), 32'd1);
        dr_fixed = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        wait_accept(8'h12, 8'h34, 1'b0, 1'b0);
        chk("bp_handshake_edge", 32'(last_hs), 32'(hs));
        chk("bp_next_accept", 32'(acc_q[acc_q.size()-1]), 32'(hs + 1));
        drain();

        // abort mid-RUN
        @(negedge clk);
        drive(8'hAA, 8'h55, 1'b1, 1'b0);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_done_valid", 32'(bus.done_valid), 32'd0);
        chk("abort_sum", 32'(bus.sum_out), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        repeat (12) @(negedge clk);

        // WIDTH=1 instance
        bus1.a_in = 1'b1;
        bus1.b_in = 1'b1;
        bus1.cin = 1'b1;
        bus1.start_valid = 1'b1;
        chk("w1_ready", 32'(bus1.start_ready), 32'd1);
        @(negedge clk);
        bus1.start_valid = 1'b0;
        chk("w1_run_not_done", 32'(bus1.done_valid), 32'd0);
        @(negedge clk);
        chk("w1_done", 32'(bus1.done_valid), 32'd1);
        chk("w1_result", {30'd0, bus1.cout, bus1.sum_out}, 32'd3);
        @(negedge clk);
        chk("w1_idle", 32'(bus1.start_ready), 32'd1);

        // random traffic with random backpressure
        rand_dr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (i % 7 == 0) rb = ~ra;
            send(ra, rb, rc, rs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_dr = 1'b0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-multiplexes a single 1-bit full adder cell over WIDTH-bit operands, one bit per clock, LSB first. It accepts an operand pair via a valid/ready handshake and holds the carry between bits in a flop. It presents the WIDTH-bit sum and final carry-out on a second valid/ready handshake. It is the area-minimal arithmetic path for control-plane counters and accumulators that do not need single-cycle addition.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operand pair a_in/b_in/cin is presented.
- start_ready  out  1  block can accept operands; high only in IDLE.
- a_in  in  WIDTH  operand A; sampled only on the start handshake.
- b_in  in  WIDTH  operand B; sampled only on the start handshake.
- cin  in  1  carry-in for bit 0; sampled only on the start handshake.
- done_valid  out  1  sum_out/cout hold a completed result.
- done_ready  in  1  consumer accepts the result.
- sum_out  out  WIDTH  result, A+B+cin mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. If start_valid is high, the block loads the A/B shift registers and the carry flop (=cin), clears the bit counter, and goes to RUN.
- RUN, one bit per cycle:
  - The full adder takes A[0], B[0] and the carry flop.
  - The sum bit shifts into the result register from the MSB side.
  - The carry flop takes the adder carry.
  - A and B shift right by one.
  - The counter increments. When the counter equals WIDTH-1, the next state is DONE.
- DONE: done_valid=1. sum_out and cout are held stable until the cycle with done_ready=1, which returns the block to IDLE.
- start_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- No back-to-back overlap. A new start can be accepted at the earliest on the cycle after the done handshake.
- Counter width is max(1, $clog2(WIDTH)). WIDTH=1 spends exactly one cycle in RUN.
- cout equals the carry flop after the last RUN cycle; no other flags are produced.

## Timing
- Reset: state=IDLE, start_ready=1, done_valid=0, sum_out=0, cout=0. Reset clears the counter and all shift registers.
- Latency:
  - The start handshake occurs at edge k.
  - RUN occupies edges k+1 … k+WIDTH.
  - done_valid rises after edge k+WIDTH.
  - Minimum accept-to-accept spacing is WIDTH+2 cycles.
- start_ready and done_valid are decoded from registered state only; there is no combinational path from inputs to outputs.
- rst asserted in RUN or DONE aborts the operation: the block returns to IDLE with reset values and never produces done_valid for the aborted operation.
- If done_ready is held high continuously, DONE lasts exactly one cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port `sub` (1 bit), sampled on the start handshake.
  - When sub=1, the block loads ~b_in and forces the initial carry to 1, so the result is A−B. The cin port is ignored for subtracts.
  - cout=1 means no borrow.
- Not defined: port `sub` is absent and the block is add-only; the logic is otherwise identical.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing the counter width from WIDTH.
- One sub-module: the existing full_adder cell (ports a, b, c, sum, cout), instantiated once for the per-bit arithmetic. The controller holds only the FSM, counter, shift registers and carry flop.

## Test plan
- WIDTH=8, a_in=0x5A, b_in=0x3C, cin=0, done_ready=1 → done_valid exactly 8 cycles after the accept edge; sum_out=0x96, cout=0.
- a_in=0xFF, b_in=0x01, cin=0 → sum_out=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 → sum_out=0xFF, cout=1.
- Backpressure: done_ready low for 5 cycles after done_valid rises, with start_valid high throughout → sum_out/cout stable, start_ready=0, no new accept. The next accept occurs one cycle after the done handshake.
- Reset mid-operation: assert rst after bit 3 of RUN → next cycle state IDLE, start_ready=1, sum_out=0. done_valid never rises for that operation.
- WIDTH=1: a_in=1, b_in=1, cin=1 → sum_out=1, cout=1, done_valid one cycle after the accept edge.
- With SERIAL_ADDER_SUB_EN: sub=1, a_in=0x10, b_in=0x01 → sum_out=0x0F, cout=1. sub=1, a_in=0x01, b_in=0x02 → sum_out=0xFF, cout=0.
